// File: rtl/dac_pkg.sv
// Shared definitions for the Pmod DAC path: command codes, frame layout and
// sequencer state encoding.
package dac_pkg;

   localparam int unsigned FRAME_W      = 32;
   localparam int unsigned CMD_LSB      = 24;
   localparam int unsigned CMD_W        = 4;
   localparam int unsigned ADDR_LSB     = 20;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned DATA_LSB     = 8;
   localparam int unsigned DATA_FIELD_W = 12;
   localparam int unsigned MAX_CH       = 8;

   localparam logic [3:0] CMD_WR_UPD  = 4'h3;
   localparam logic [3:0] CMD_SW_RST  = 4'h7;
   localparam logic [3:0] CMD_REF_SET = 4'h8;

   typedef enum logic [1:0] {
      ST_INIT_RST,
      ST_INIT_REF,
      ST_IDLE,
      ST_SEND
   } seq_state_t;

   function automatic logic [FRAME_W-1:0] make_frame(
      input logic [CMD_W-1:0]        cmd,
      input logic [ADDR_W-1:0]       addr,
      input logic [DATA_FIELD_W-1:0] data,
      input logic [7:0]              tail
   );
      logic [FRAME_W-1:0] f;
      f = '0;
      f[CMD_LSB  +: CMD_W]        = cmd;
      f[ADDR_LSB +: ADDR_W]       = addr;
      f[DATA_LSB +: DATA_FIELD_W] = data;
      f[7:0]                      = tail;
      return f;
   endfunction

   // Reference-enable frame sets DB0 in the low byte, outside the data field
   localparam logic [FRAME_W-1:0] FRAME_SW_RST = make_frame(CMD_SW_RST, 4'h0, 12'h000, 8'h00);
   localparam logic [FRAME_W-1:0] FRAME_REF_ON = make_frame(CMD_REF_SET, 4'h0, 12'h000, 8'h01);

endpackage

// File: rtl/dac_frame_sequencer_rr_pick.sv
// Round-robin find-first-set: first set bit of dirty at or after rr_ptr,
// wrapping from NUM_CH-1 back to 0.
module rr_pick #(
   parameter int unsigned NUM_CH = 8
) (
   input  logic [NUM_CH-1:0] dirty,
   input  logic [2:0]        rr_ptr,
   output logic              found,
   output logic [2:0]        index
);

   int unsigned k;

   always_comb begin
      found = 1'b0;
      index = '0;
      k     = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         // rr_ptr is always < NUM_CH, so a single subtract wraps the sum
         k = 32'(rr_ptr) + i;
         if (k >= NUM_CH) k = k - NUM_CH;
         if (!found && dirty[k]) begin
            found = 1'b1;
            index = 3'(k);
         end
      end
   end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Pmod DAC frame sequencer: power-up command sequence, per-channel shadow
// samples, and round-robin launch of write-and-update frames to the serializer.
module dac_frame_sequencer
   import dac_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned DATA_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enb,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [2:0]        s_chan,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       m_frame,
   output logic              init_done,
   output logic              err_chan
);

   seq_state_t state, state_nxt;

   logic [DATA_FIELD_W-1:0] shadow [MAX_CH];
   logic [MAX_CH-1:0]       dirty;
   logic [2:0]              rr_ptr, rr_nxt;
   logic [2:0]              sel_ch;
   logic                    valid_nxt, done_nxt, launch;
   logic [31:0]             frame_nxt;
   logic                    pick_found;
   logic [2:0]              pick_idx;
   logic                    chan_ok, wr_ok, wr_bad;
   logic [DATA_FIELD_W-1:0] s_data_lj;

   assign s_ready   = init_done;
   assign chan_ok   = (32'(s_chan) < NUM_CH);
   assign wr_ok     = s_valid && s_ready && chan_ok;
   assign wr_bad    = s_valid && s_ready && !chan_ok;
   assign s_data_lj = 12'(s_data) << (DATA_FIELD_W - DATA_W);

   rr_pick #(.NUM_CH(NUM_CH)) u_pick (
      .dirty  (dirty[NUM_CH-1:0]),
      .rr_ptr (rr_ptr),
      .found  (pick_found),
      .index  (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_INIT_RST;
         m_valid   <= 1'b0;
         m_frame   <= '0;
         init_done <= 1'b0;
         err_chan  <= 1'b0;
         dirty     <= '0;
         rr_ptr    <= '0;
         sel_ch    <= '0;
         for (int unsigned i = 0; i < MAX_CH; i++) shadow[i] <= '0;
      end else if (clk_enb) begin
         state     <= state_nxt;
         m_valid   <= valid_nxt;
         m_frame   <= frame_nxt;
         init_done <= done_nxt;
         rr_ptr    <= rr_nxt;
         err_chan  <= wr_bad;
         if (launch) begin
            dirty[pick_idx] <= 1'b0;
            sel_ch          <= pick_idx;
         end
         // A same-edge write to the launching channel wins, keeping it dirty
         if (wr_ok) begin
            shadow[s_chan] <= s_data_lj;
            dirty[s_chan]  <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT_RST: if (m_valid && m_ready) state_nxt = ST_INIT_REF;
         ST_INIT_REF: if (m_valid && m_ready) state_nxt = ST_IDLE;
         ST_IDLE:     if (pick_found)         state_nxt = ST_SEND;
         ST_SEND:     if (m_valid && m_ready) state_nxt = ST_IDLE;
         default:                             state_nxt = ST_INIT_RST;
      endcase
   end

   always_comb begin
      valid_nxt = m_valid;
      frame_nxt = m_frame;
      done_nxt  = init_done;
      rr_nxt    = rr_ptr;
      launch    = 1'b0;
      case (state)
         ST_INIT_RST: begin
            if (!m_valid) begin
               valid_nxt = 1'b1;
               frame_nxt = FRAME_SW_RST;
            end else if (m_ready) begin
               frame_nxt = FRAME_REF_ON;
            end
         end
         ST_INIT_REF: begin
            if (m_valid && m_ready) begin
               valid_nxt = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         ST_IDLE: begin
            if (pick_found) begin
               launch    = 1'b1;
               valid_nxt = 1'b1;
               frame_nxt = make_frame(CMD_WR_UPD, {1'b0, pick_idx}, shadow[pick_idx], 8'h00);
            end
         end
         ST_SEND: begin
            if (m_valid && m_ready) begin
               valid_nxt = 1'b0;
               rr_nxt    = (32'(sel_ch) + 1 >= NUM_CH) ? 3'd0 : sel_ch + 3'd1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench for dac_frame_sequencer: expected frames are queued as
// stimulus is driven and popped by a handshake monitor per DUT instance.
module tb_dac_frame_sequencer;
   import dac_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clk_enb, s_valid, m_ready;
   logic [2:0]  s_chan;
   logic [11:0] s_data;
   logic        s_ready, m_valid, init_done, err_chan;
   logic [31:0] m_frame;

   logic        clk_enb4, s_valid4, m_ready4;
   logic [2:0]  s_chan4;
   logic [7:0]  s_data4;
   logic        s_ready4, m_valid4, init_done4, err_chan4;
   logic [31:0] m_frame4;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   logic [31:0] q[$];
   logic [31:0] q4[$];

   dac_frame_sequencer #(.NUM_CH(8), .DATA_W(12)) dut (
      .clk(clk), .reset(reset), .clk_enb(clk_enb),
      .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_frame(m_frame),
      .init_done(init_done), .err_chan(err_chan)
   );

   dac_frame_sequencer #(.NUM_CH(4), .DATA_W(8)) dut4 (
      .clk(clk), .reset(reset), .clk_enb(clk_enb4),
      .s_valid(s_valid4), .s_ready(s_ready4), .s_chan(s_chan4), .s_data(s_data4),
      .m_valid(m_valid4), .m_ready(m_ready4), .m_frame(m_frame4),
      .init_done(init_done4), .err_chan(err_chan4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && clk_enb && m_valid && m_ready) begin
         check("frame_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) check("frame", m_frame, q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (reset && clk_enb4 && m_valid4 && m_ready4) begin
         check("frame4_expected", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) check("frame4", m_frame4, q4.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] d);
      s_valid = 1'b1; s_chan = ch; s_data = d;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic wr4(input logic [2:0] ch, input logic [7:0] d);
      s_valid4 = 1'b1; s_chan4 = ch; s_data4 = d;
      @(posedge clk); #1;
      s_valid4 = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 60 && (q.size() != 0 || q4.size() != 0); i++) step(1);
      check(tag, 32'(q.size() + q4.size()), 32'd0);
   endtask

   task automatic wait_init(input string tag);
      for (int i = 0; i < 20 && !(init_done && init_done4); i++) step(1);
      check(tag, {30'd0, init_done, init_done4}, 32'd3);
   endtask

   initial begin
      reset = 1'b0; clk_enb = 1'b1; m_ready = 1'b1;
      s_valid = 1'b0; s_chan = '0; s_data = '0;
      clk_enb4 = 1'b1; m_ready4 = 1'b1;
      s_valid4 = 1'b0; s_chan4 = '0; s_data4 = '0;

      // 1: reset state, then power-up sequence
      step(3);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_frame", m_frame, 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_err_chan", 32'(err_chan), 32'd0);
      q.push_back(32'h0700_0000);  q.push_back(32'h0800_0001);
      q4.push_back(32'h0700_0000); q4.push_back(32'h0800_0001);
      reset = 1'b1;
      wait_init("init_done");
      check("s_ready_after_init", 32'(s_ready), 32'd1);
      drain("init_frames");

      // 2: single write, one-cycle launch latency
      q.push_back(32'h033A_BC00);
      wr(3'd3, 12'hABC);
      @(negedge clk) check("lat_edge_n", 32'(m_valid), 32'd0);
      @(negedge clk) check("lat_edge_n1", 32'(m_valid), 32'd1);
      step(6);
      drain("single_write");

      // 3: stalled frame stays stable, repeated writes coalesce
      m_ready = 1'b0;
      q.push_back(32'h0351_1100);
      wr(3'd5, 12'h111);
      wr(3'd3, 12'h111);
      wr(3'd3, 12'h222);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_frame", m_frame, 32'h0351_1100);
         check("stall_valid", 32'(m_valid), 32'd1);
      end
      @(posedge clk); #1;
      q.push_back(32'h0332_2200);
      m_ready = 1'b1;
      step(8);
      drain("coalesce");

      // 4: burst while ch3 frame stalls; after it rr_ptr=4 so ch7 leads
      m_ready = 1'b0;
      q.push_back(32'h0331_2300);
      wr(3'd3, 12'h123);
      wr(3'd0, 12'h0A0);
      wr(3'd2, 12'h0C2);
      wr(3'd7, 12'h7F7);
      q.push_back(32'h0377_F700);
      q.push_back(32'h0300_A000);
      q.push_back(32'h0320_C200);
      m_ready = 1'b1;
      step(10);
      drain("rr_wrap");

      // 5: clock enable low freezes handshake, writes and state
      m_ready = 1'b0;
      q.push_back(32'h0313_2100);
      q.push_back(32'h0344_4400);
      wr(3'd1, 12'h321);
      wr(3'd4, 12'h444);
      clk_enb = 1'b0; m_ready = 1'b1;
      s_valid = 1'b1; s_chan = 3'd6; s_data = 12'h666;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("enb_frame", m_frame, 32'h0313_2100);
         check("enb_valid", 32'(m_valid), 32'd1);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; clk_enb = 1'b1;
      step(8);
      drain("clk_enb_hold");

      // 5b: out-of-range channel on a 4-channel, 8-bit instance
      wr4(3'd7, 8'hEE);
      @(negedge clk) check("err_pulse_hi", 32'(err_chan4), 32'd1);
      @(negedge clk) check("err_pulse_lo", 32'(err_chan4), 32'd0);
      @(posedge clk); #1;
      step(4);
      check("err_no_frame", 32'(m_valid4), 32'd0);
      q4.push_back(32'h032A_B000);
      wr4(3'd2, 8'hAB);
      step(4);
      drain("left_justify");

      // 6: reset while a frame is pending in SEND
      m_ready = 1'b0;
      wr(3'd2, 12'h555);
      step(1);
      check("send_pending_frame", m_frame, 32'h0325_5500);
      check("send_pending_valid", 32'(m_valid), 32'd1);
      reset = 1'b0;
      step(1);
      check("rst_send_valid", 32'(m_valid), 32'd0);
      check("rst_send_done", 32'(init_done), 32'd0);
      check("rst_send_ready", 32'(s_ready), 32'd0);
      check("rst_send_frame", m_frame, 32'd0);
      m_ready = 1'b1;
      q.push_back(32'h0700_0000);  q.push_back(32'h0800_0001);
      q4.push_back(32'h0700_0000); q4.push_back(32'h0800_0001);
      reset = 1'b1;
      wait_init("reinit_done");
      drain("reinit_frames");
      step(10);
      check("post_reset_idle", 32'(m_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
